// File: rtl/pc_gen.sv
// Fetch-address generator for the IF stage: stall, redirect, one-entry pending-redirect buffer.
// Optional exception entry (epc capture, vectored load) is built only when PC_GEN_EXC_EN is defined.
module pc_gen #(
  parameter int unsigned        ADDR_W       = 32,
  parameter logic [ADDR_W-1:0]  RESET_VECTOR = '0,
  parameter int unsigned        INC          = 4,
  parameter int unsigned        ALIGN_BITS   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              redir_valid,
  input  logic [ADDR_W-1:0] redir_target,
`ifdef PC_GEN_EXC_EN
  input  logic              exc_valid,
  input  logic [ADDR_W-1:0] exc_vector,
  output logic [ADDR_W-1:0] epc,
`endif
  output logic [ADDR_W-1:0] pc,
  output logic              ce,
  output logic              pend_valid,
  output logic              misalign
);

  // All-ones when ALIGN_BITS is 0, so no masking and no misalign in that case.
  localparam logic [ADDR_W-1:0] AlignMask = ~((ADDR_W'(1) << ALIGN_BITS) - ADDR_W'(1));

  typedef enum logic [1:0] {
    StOff      = 2'd0,
    StRun      = 2'd1,
    StHoldPend = 2'd2
  } state_e;

  state_e            state;
  logic [ADDR_W-1:0] pend_target;

  logic [ADDR_W-1:0] target_aligned;
  logic              target_misaligned;
  logic [ADDR_W-1:0] pc_inc;
  logic              exc_take;
  logic [ADDR_W-1:0] exc_aligned;

  assign target_aligned    = redir_target & AlignMask;
  assign target_misaligned = |(redir_target & ~AlignMask);
  assign pc_inc            = pc + ADDR_W'(INC);

`ifdef PC_GEN_EXC_EN
  assign exc_take    = exc_valid;
  assign exc_aligned = exc_vector & AlignMask;
`else
  assign exc_take    = 1'b0;
  assign exc_aligned = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= StOff;
      pc          <= RESET_VECTOR;
      ce          <= 1'b0;
      pend_valid  <= 1'b0;
      pend_target <= '0;
      misalign    <= 1'b0;
`ifdef PC_GEN_EXC_EN
      epc         <= RESET_VECTOR;
`endif
    end else begin
      misalign <= 1'b0;
      unique case (state)
        StOff: begin
          // First enabled fetch presents the reset vector; redirects are ignored here.
          state <= StRun;
          ce    <= 1'b1;
          pc    <= RESET_VECTOR;
        end

        StRun: begin
          if (exc_take) begin
`ifdef PC_GEN_EXC_EN
            epc <= pc;
`endif
            pc          <= exc_aligned;
            pend_target <= '0;
            pend_valid  <= 1'b0;
            state       <= StRun;
          end else if (redir_valid) begin
            misalign <= target_misaligned;
            if (stall) begin
              pend_target <= target_aligned;
              pend_valid  <= 1'b1;
              state       <= StHoldPend;
            end else begin
              pc <= target_aligned;
            end
          end else if (!stall) begin
            pc <= pc_inc;
          end
        end

        StHoldPend: begin
          if (exc_take) begin
`ifdef PC_GEN_EXC_EN
            epc <= pc;
`endif
            pc          <= exc_aligned;
            pend_target <= '0;
            pend_valid  <= 1'b0;
            state       <= StRun;
          end else if (redir_valid) begin
            // Newest redirect wins over whatever is buffered.
            misalign    <= target_misaligned;
            pend_target <= target_aligned;
            if (!stall) begin
              pc         <= target_aligned;
              pend_valid <= 1'b0;
              state      <= StRun;
            end
          end else if (!stall) begin
            pc         <= pend_target;
            pend_valid <= 1'b0;
            state      <= StRun;
          end
        end

        default: begin
          state      <= StOff;
          ce         <= 1'b0;
          pc         <= RESET_VECTOR;
          pend_valid <= 1'b0;
        end
      endcase
    end
  end

  a_pend_matches_state: assert property (@(posedge clk) disable iff (rst)
    pend_valid == (state == StHoldPend));

  a_ce_matches_state: assert property (@(posedge clk) disable iff (rst)
    ce == (state != StOff));

  a_off_holds_reset_vector: assert property (@(posedge clk) disable iff (rst)
    !ce |-> (pc == RESET_VECTOR));

endmodule

// File: tb/tb_pc_gen.sv
// Table-driven bench for pc_gen: directed vectors plus hand-written stall and exception sequences.
// Builds with or without PC_GEN_EXC_EN.
module tb_pc_gen;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redir_valid;
  logic [31:0] redir_target;
  logic [31:0] pc;
  logic        ce;
  logic        pend_valid;
  logic        misalign;
`ifdef PC_GEN_EXC_EN
  logic        exc_valid;
  logic [31:0] exc_vector;
  logic [31:0] epc;
`endif

  int n_checks;
  int n_pass;

  pc_gen #(
    .ADDR_W      (32),
    .RESET_VECTOR(32'h0000_0000),
    .INC         (4),
    .ALIGN_BITS  (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redir_valid (redir_valid),
    .redir_target(redir_target),
`ifdef PC_GEN_EXC_EN
    .exc_valid   (exc_valid),
    .exc_vector  (exc_vector),
    .epc         (epc),
`endif
    .pc          (pc),
    .ce          (ce),
    .pend_valid  (pend_valid),
    .misalign    (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        rv;
    logic [31:0] tgt;
    logic [31:0] pc;
    logic        ce;
    logic        pend;
    logic        mis;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic s, input logic v, input logic [31:0] t,
                     input logic [31:0] p, input logic c, input logic pd, input logic m);
    vec_t e;
    e.rst = r; e.stall = s; e.rv = v; e.tgt = t;
    e.pc = p; e.ce = c; e.pend = pd; e.mis = m;
    vq.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Drive on the falling edge, step one rising edge, sample 1 time unit later.
  task automatic step(input logic r, input logic s, input logic v, input logic [31:0] t);
    @(negedge clk);
    rst = r; stall = s; redir_valid = v; redir_target = t;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b1; stall = 1'b0; redir_valid = 1'b0; redir_target = '0;
`ifdef PC_GEN_EXC_EN
    exc_valid = 1'b0; exc_vector = '0;
`endif

    //   rst   stall rv    target        pc            ce    pend  mis
    // Reset for three cycles, then sequential fetch.
    add(1'b1, 1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 32'h0,        32'h4,        1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 32'h0,        32'h8,        1'b1, 1'b0, 1'b0);
    // Redirect at pc=8.
    add(1'b0, 1'b0, 1'b1, 32'h100,      32'h100,      1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 32'h0,        32'h104,      1'b1, 1'b0, 1'b0);
    // Stalled redirect from pc=0x10.
    add(1'b0, 1'b0, 1'b1, 32'h10,       32'h10,       1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 32'h0,        32'h10,       1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 32'h200,      32'h10,       1'b1, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b0, 32'h0,        32'h10,       1'b1, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b0, 32'h0,        32'h10,       1'b1, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 32'h0,        32'h200,      1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 32'h0,        32'h204,      1'b1, 1'b0, 1'b0);
    // Overwrite in HOLD_PEND, then redirect on release.
    add(1'b0, 1'b1, 1'b1, 32'h200,      32'h204,      1'b1, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b1, 32'h300,      32'h204,      1'b1, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b1, 32'h400,      32'h400,      1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 32'h0,        32'h404,      1'b1, 1'b0, 1'b0);
    // Wrap-around.
    add(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFF8, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 32'h0,        32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 32'h0,        32'h4,        1'b1, 1'b0, 1'b0);
    // Misaligned target, loaded and buffered.
    add(1'b0, 1'b0, 1'b1, 32'h103,      32'h100,      1'b1, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b0, 32'h0,        32'h104,      1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 32'h2,        32'h104,      1'b1, 1'b1, 1'b1);
    add(1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 32'h0,        32'h4,        1'b1, 1'b0, 1'b0);
    // Reset with a pending redirect; OFF-state redirect ignored.
    add(1'b0, 1'b1, 1'b1, 32'h500,      32'h4,        1'b1, 1'b1, 1'b0);
    add(1'b1, 1'b1, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 32'h700,      32'h0,        1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 32'h0,        32'h4,        1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 32'h0,        32'h8,        1'b1, 1'b0, 1'b0);

    foreach (vq[i]) begin
      step(vq[i].rst, vq[i].stall, vq[i].rv, vq[i].tgt);
      check($sformatf("pc[%0d]", i),   pc,                  vq[i].pc);
      check($sformatf("ce[%0d]", i),   {31'b0, ce},         {31'b0, vq[i].ce});
      check($sformatf("pend[%0d]", i), {31'b0, pend_valid}, {31'b0, vq[i].pend});
      check($sformatf("mis[%0d]", i),  {31'b0, misalign},   {31'b0, vq[i].mis});
    end

    // Long stall with a buffered target: pc must hold every cycle, then load once.
    step(1'b0, 1'b1, 1'b1, 32'h800);
    for (int k = 0; k < 6; k++) begin
      step(1'b0, 1'b1, 1'b0, 32'h0);
      check($sformatf("long_stall_pc[%0d]", k), pc, 32'h8);
      check($sformatf("long_stall_pend[%0d]", k), {31'b0, pend_valid}, 32'h1);
    end
    step(1'b0, 1'b0, 1'b0, 32'h0);
    check("long_stall_release_pc", pc, 32'h800);
    check("long_stall_release_pend", {31'b0, pend_valid}, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    check("long_stall_after_pc", pc, 32'h804);

`ifdef PC_GEN_EXC_EN
    // Exception during a stall with a pending redirect.
    step(1'b0, 1'b0, 1'b1, 32'h40);
    check("exc_setup_pc", pc, 32'h40);
    step(1'b0, 1'b1, 1'b1, 32'h600);
    check("exc_pend_set", {31'b0, pend_valid}, 32'h1);
    @(negedge clk);
    exc_valid = 1'b1; exc_vector = 32'h180; redir_valid = 1'b0;
    @(posedge clk);
    #1;
    check("exc_pc", pc, 32'h180);
    check("exc_epc", epc, 32'h40);
    check("exc_pend_clear", {31'b0, pend_valid}, 32'h0);
    @(negedge clk);
    exc_valid = 1'b0;
    step(1'b0, 1'b0, 1'b0, 32'h0);
    check("exc_after_pc", pc, 32'h184);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised next-generation program-counter / fetch-address generator for the pipelined MIPS32 core; sits at the head of the IF stage and drives the instruction-ROM address and chip enable.
- Adds what the basic PC lacks:
  - configurable width, reset vector and increment;
  - pipeline stall;
  - branch/jump redirect;
  - a one-entry pending-redirect buffer, so a redirect arriving during a stall is never lost;
  - target-alignment checking.

Parameters:
- ADDR_W, 32, width of pc and redirect target.
- RESET_VECTOR, 32'h0000_0000, pc value while fetch is disabled and after reset.
- INC, 4, sequential increment added to pc each advancing cycle.
- ALIGN_BITS, 2, number of low target bits that must be zero; forced to zero on load.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- stall  input  1  hold pc this cycle (downstream not ready).
- redir_valid  input  1  redirect request (taken branch / jump) this cycle.
- redir_target  input  ADDR_W  redirect destination, sampled when redir_valid=1.
- pc  output  ADDR_W  current fetch address (registered).
- ce  output  1  instruction-memory chip enable (registered; 1 = ChipEnable).
- pend_valid  output  1  a redirect is buffered awaiting stall release.
- misalign  output  1  one-cycle registered pulse: an accepted target had non-zero low ALIGN_BITS.

Behaviour:
- Reset and enable:
  - On any clock edge with rst=1: ce<=0, pc<=RESET_VECTOR, pend_valid<=0, pend buffer<=0, misalign<=0, state<=OFF. This applies even mid-stall or with a pending redirect (buffer discarded).
  - ce rises on the first edge with rst=0. While ce=0 (state OFF), pc is held at RESET_VECTOR regardless of stall/redir_valid. redir_valid is ignored and never captured.
  - The first fetch address presented with ce=1 is RESET_VECTOR. pc advances starting on the following edge.
- States:
  - OFF: ce=0. Next state RUN when rst=0.
  - RUN: ce=1, no pending redirect.
  - HOLD_PEND: ce=1, pending redirect held in the buffer.
- RUN transitions, evaluated in priority order on each edge (ce=1):
  1. stall=1 and redir_valid=1: pc holds. Capture the aligned redir_target into the buffer, pend_valid<=1, go to HOLD_PEND.
  2. stall=0 and redir_valid=1: pc<=aligned redir_target. Stay in RUN.
  3. stall=1 and redir_valid=0: pc holds. Stay in RUN.
  4. Otherwise: pc<=pc+INC. Stay in RUN.
- HOLD_PEND transitions:
  1. redir_valid=1 (any stall): the newer target overwrites the buffer (newest wins). If stall=0 in the same cycle, pc<=new aligned target directly, pend_valid<=0, go to RUN.
  2. stall=1, redir_valid=0: pc holds, buffer holds.
  3. stall=0, redir_valid=0: pc<=buffer, pend_valid<=0, go to RUN.
- Redirect latency: redir_valid sampled at edge N appears on pc after edge N (1 cycle). When stalled, it appears 1 cycle after the first stall=0 edge.
- Arithmetic:
  - pc+INC wraps modulo 2^ADDR_W, with no flag and no saturation. Example: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
  - Aligned target = redir_target with low ALIGN_BITS cleared. ALIGN_BITS=0 means no masking, and misalign never asserts.
- misalign: set for exactly one cycle on the edge at which a target with non-zero low bits is accepted (loaded or buffered); otherwise 0.
- pend_valid is 1 iff state == HOLD_PEND.

Optional Feature:
- Macro PC_GEN_EXC_EN.
- When defined, adds ports:
  - exc_valid input 1;
  - exc_vector input ADDR_W;
  - epc output ADDR_W.
- exc_valid has highest priority over stall, redir_valid and the pending buffer. In RUN or HOLD_PEND with exc_valid=1: epc<=current pc, pc<=aligned exc_vector, buffer cleared, pend_valid<=0, state RUN.
- epc resets to RESET_VECTOR. exc_valid is ignored while ce=0.
- When not defined, these ports and this logic are absent, and behaviour is exactly as above.

Test Plan:
- Reset release: rst=1 for 3 cycles then 0, stall=0 -> ce=0,pc=0 during reset; ce=1,pc=0 first cycle after; then pc=4,8,12 on successive cycles.
- Redirect: at pc=8 assert redir_valid with target=32'h100 for 1 cycle -> next pc=32'h100, then 32'h104.
- Stalled redirect: stall=1 for 4 cycles starting at pc=0x10; in stall cycle 2 redir_valid with target 0x200 -> pc stays 0x10, pend_valid=1 for the rest of the stall; first stall=0 edge pc=0x200, pend_valid=0.
- Overwrite and simultaneous release: in HOLD_PEND holding 0x200, redir to 0x300 with stall=1, then redir 0x400 with stall=0 -> pc=0x400, never 0x200/0x300.
- Wrap and alignment: force pc via redirect to 32'hFFFF_FFF8 -> pc=FFFF_FFFC then 0000_0000; redirect target 0x103 -> pc=0x100, misalign pulses for 1 cycle.
- Reset mid-operation: rst=1 while pend_valid=1 -> next edge ce=0, pc=RESET_VECTOR, pend_valid=0; after release the buffered target never appears. With PC_GEN_EXC_EN: exc_valid with vector 0x180 during stall at pc=0x40 -> pc=0x180, epc=0x40.
